dma_engine: RTL and testbench
=============================

// Module: dma_engine
// PURPOSE
//  Initiator side of the DmaBus/dma_req interface consumed by the memory controller. It moves
//  16-bit words between a peripheral byte stream and cart memory (rom0/rom1/sram/bram) with no
//  CPU involvement. dir=0 streams bytes into memory; dir=1 streams memory out as bytes.
//  Byte order is big-endian (68k): the first byte is [15:8], the second is [7:0].
// PARAMETERS
//  MEM_WAIT  3   clocks that dma_oe / dma_we_* stay asserted per access (legal range 1..15)
// PORTS
//  clk         in   1   system clock; all state updates on the falling edge (negedge clk)
//  rst         in   1   asynchronous, active-high reset
//  start       in   1   1-clk pulse that launches a transfer; ignored while busy=1
//  dir         in   1   0 = stream->mem (write), 1 = mem->stream (read); latched at start
//  addr_st     in   23  byte start address; bit0 forced to 0 at latch
//  len         in   16  transfer length in words; 0 = finish at once with no memory access
//  abort       in   1   stop the transfer early; done does not pulse
//  din         in   8   write-stream byte
//  din_valid   in   1   din holds a byte
//  din_ready   out  1   engine accepts din this clk
//  dout        out  8   read-stream byte
//  dout_valid  out  1   dout holds a byte
//  dout_ready  in   1   sink accepts dout this clk
//  mem_do      in   16  data returned by the selected memory
//  dma_addr    out  23  DmaBus.addr
//  dma_data    out  16  DmaBus.data (write data)
//  dma_oe      out  1   DmaBus.oe
//  dma_we_lo   out  1   DmaBus.we_lo
//  dma_we_hi   out  1   DmaBus.we_hi
//  dma_req     out  1   takes the memory bus from the mapper
//  busy        out  1   transfer in progress
//  done        out  1   1-clk pulse when the last word completes normally
// BEHAVIOUR
//  - Reset: every output is 0; state = IDLE; internal counters = 0.
//  - IDLE -> START on start & !abort. START latches dir, addr, len and the word count, then asserts busy.
//  - Same clk start and abort in IDLE: abort wins; nothing launches.
//  - START routing: len==0 -> FIN; dir=0 -> COLLECT_HI; dir=1 -> RD_SETUP.
//  - dma_req = 1 in every state except IDLE (this includes FIN, which acts as the guard clk).
//  - Write path:
//    - COLLECT_HI: din_ready=1; on din_valid, din -> dma_data[15:8], go to COLLECT_LO.
//    - COLLECT_LO: din_ready=1; on din_valid, din -> dma_data[7:0], go to WR_SETUP.
//    - WR_SETUP: 1 clk; addr and data stable; no strobe asserted.
//    - WR_PULSE: MEM_WAIT clks with dma_we_hi = dma_we_lo = 1.
//    - WR_HOLD: 1 clk; strobes 0; addr and data held. Then addr += 2 and count -= 1.
//      count==0 -> FIN, else -> COLLECT_HI.
//  - Read path:
//    - RD_SETUP: 1 clk; addr stable.
//    - RD_PULSE: MEM_WAIT clks with dma_oe=1; mem_do is captured on the last clk of the pulse.
//    - SEND_HI: dout = word[15:8], dout_valid=1; advance on dout_ready.
//    - SEND_LO: dout = word[7:0], dout_valid=1; advance on dout_ready; then addr += 2 and
//      count -= 1. count==0 -> FIN, else -> RD_SETUP.
//  - dma_oe and dma_we_* are never 1 in the same clk. Strobes are never asserted while dma_req=0.
//  - FIN: 1 clk; done=1 unless the transfer was aborted; then IDLE with busy=0 and dma_req=0.
//  - Address arithmetic is 23-bit and wraps 7FFFFE -> 000000. The count is 17-bit internal, so
//    len=FFFF transfers 65535 words.
//  - Abort in COLLECT_*, WR_SETUP, RD_SETUP or SEND_*: go to FIN on the next clk; partial bytes
//    are dropped.
//  - Abort in WR_PULSE or RD_PULSE: the pulse runs to full length (no truncated SRAM cycle),
//    then goes to FIN via WR_HOLD. Abort is sticky until FIN.
//  - Stalls: din_valid=0 or dout_ready=0 stalls indefinitely with dma_req held. No timeout.
//  - rst mid-transfer: all outputs drop to 0 asynchronously; no done pulse.
// TESTING
//  - Write, MEM_WAIT=3: addr_st=000100, len=2, bytes 12 34 56 78 -> word 1234 at 000100 and
//    word 5678 at 000102; dma_we_* high exactly 3 clks each; done 1 clk.
//  - Read: memory model holds 0xBEEF at 000200, 0xCAFE at 000202; len=2 -> dout sequence
//    BE EF CA FE; dma_oe width 3 clks; with dout_ready low 5 clks, output holds and dma_req
//    stays 1.
//  - len=0 -> busy for START+FIN only; done=1; dma_oe and dma_we_* never assert.
//  - Wrap: addr_st=7FFFFF, len=2, write -> accesses at 7FFFFE then 000000.
//  - Abort asserted in the 2nd clk of WR_PULSE -> pulse completes 3 clks; WR_HOLD, then FIN;
//    done stays 0; next start runs normally.
//  - start with abort in IDLE -> no launch. start while busy -> ignored. rst mid-RD_PULSE ->
//    dma_oe and dma_req drop to 0 at once.

Source files
------------

// File: rtl/dma_engine.sv
// DMA initiator: moves 16-bit big-endian words between a byte stream and cart memory over the DmaBus.
// All state advances on the falling clock edge; reset is asynchronous, active-high.
module dma_engine #(
  parameter int MEM_WAIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        dir,
  input  logic [22:0] addr_st,
  input  logic [15:0] len,
  input  logic        abort,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [7:0]  dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  input  logic [15:0] mem_do,
  output logic [22:0] dma_addr,
  output logic [15:0] dma_data,
  output logic        dma_oe,
  output logic        dma_we_lo,
  output logic        dma_we_hi,
  output logic        dma_req,
  output logic        busy,
  output logic        done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_COLLECT_HI,
    S_COLLECT_LO,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_RD_SETUP,
    S_RD_PULSE,
    S_SEND_HI,
    S_SEND_LO,
    S_FIN
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

  state_t      state_q, state_d;
  logic        dir_q, dir_d;
  logic [22:0] addr_q, addr_d;
  logic [16:0] count_q, count_d;
  logic [15:0] data_q, data_d;
  logic [15:0] word_q, word_d;
  logic [3:0]  wait_q, wait_d;
  logic        abort_q, abort_d;
  logic        abort_any;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      addr_q  <= '0;
      count_q <= '0;
      data_q  <= '0;
      word_q  <= '0;
      wait_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      data_q  <= data_d;
      word_q  <= word_d;
      wait_q  <= wait_d;
      abort_q <= abort_d;
    end
  end

  assign abort_any = abort | abort_q;

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    addr_d     = addr_q;
    count_d    = count_q;
    data_d     = data_q;
    word_d     = word_q;
    wait_d     = wait_q;
    abort_d    = abort_q;
    din_ready  = 1'b0;
    dout       = 8'h00;
    dout_valid = 1'b0;
    dma_oe     = 1'b0;
    dma_we_lo  = 1'b0;
    dma_we_hi  = 1'b0;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_START;
          dir_d   = dir;
          addr_d  = {addr_st[22:1], 1'b0};
          count_d = {1'b0, len};
          abort_d = 1'b0;
        end
      end
      S_START: begin
        if (abort) begin
          abort_d = 1'b1;
          state_d = S_FIN;
        end else if (count_q == 17'd0) begin
          state_d = S_FIN;
        end else if (dir_q) begin
          state_d = S_RD_SETUP;
        end else begin
          state_d = S_COLLECT_HI;
        end
      end
      S_COLLECT_HI: begin
        din_ready = 1'b1;
        if (abort) begin
          abort_d = 1'b1;
          state_d = S_FIN;
        end else if (din_valid) begin
          data_d[15:8] = din;
          state_d      = S_COLLECT_LO;
        end
      end
      S_COLLECT_LO: begin
        din_ready = 1'b1;
        if (abort) begin
          abort_d = 1'b1;
          state_d = S_FIN;
        end else if (din_valid) begin
          data_d[7:0] = din;
          state_d     = S_WR_SETUP;
        end
      end
      S_WR_SETUP: begin
        if (abort) begin
          abort_d = 1'b1;
          state_d = S_FIN;
        end else begin
          wait_d  = WAIT_LAST;
          state_d = S_WR_PULSE;
        end
      end
      // Strobe pulses always run full length so the memory never sees a truncated cycle.
      S_WR_PULSE: begin
        dma_we_hi = 1'b1;
        dma_we_lo = 1'b1;
        abort_d   = abort_any;
        if (wait_q == 4'd0) begin
          state_d = S_WR_HOLD;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_WR_HOLD: begin
        addr_d  = addr_q + 23'd2;
        count_d = count_q - 17'd1;
        abort_d = abort_any;
        if (abort_any || count_q == 17'd1) begin
          state_d = S_FIN;
        end else begin
          state_d = S_COLLECT_HI;
        end
      end
      S_RD_SETUP: begin
        if (abort) begin
          abort_d = 1'b1;
          state_d = S_FIN;
        end else begin
          wait_d  = WAIT_LAST;
          state_d = S_RD_PULSE;
        end
      end
      S_RD_PULSE: begin
        dma_oe  = 1'b1;
        abort_d = abort_any;
        if (wait_q == 4'd0) begin
          word_d  = mem_do;
          state_d = abort_any ? S_WR_HOLD : S_SEND_HI;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_SEND_HI: begin
        dout       = word_q[15:8];
        dout_valid = 1'b1;
        if (abort) begin
          abort_d = 1'b1;
          state_d = S_FIN;
        end else if (dout_ready) begin
          state_d = S_SEND_LO;
        end
      end
      S_SEND_LO: begin
        dout       = word_q[7:0];
        dout_valid = 1'b1;
        if (abort) begin
          abort_d = 1'b1;
          state_d = S_FIN;
        end else if (dout_ready) begin
          addr_d  = addr_q + 23'd2;
          count_d = count_q - 17'd1;
          state_d = (count_q == 17'd1) ? S_FIN : S_RD_SETUP;
        end
      end
      S_FIN: begin
        done    = !abort_q;
        abort_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dma_req  = (state_q != S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign dma_addr = addr_q;
  assign dma_data = data_q;

endmodule

// File: tb/tb_dma_engine.sv
// Directed bench for dma_engine: table of whole transfers plus hand sequences for stall, abort and reset.
// Inputs are driven and outputs sampled on the rising edge; the DUT updates on the falling edge.
module tb_dma_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, dir, abort, din_valid, dout_ready;
  logic [22:0] addr_st;
  logic [15:0] len, mem_do;
  logic [7:0]  din;
  logic        din_ready, dout_valid, dma_oe, dma_we_lo, dma_we_hi, dma_req, busy, done;
  logic [7:0]  dout;
  logic [22:0] dma_addr;
  logic [15:0] dma_data;

  dma_engine #(.MEM_WAIT(3)) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .addr_st(addr_st), .len(len),
    .abort(abort), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .mem_do(mem_do),
    .dma_addr(dma_addr), .dma_data(dma_data), .dma_oe(dma_oe), .dma_we_lo(dma_we_lo),
    .dma_we_hi(dma_we_hi), .dma_req(dma_req), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dir;
    logic [22:0] addr;
    logic [15:0] len;
    logic [22:0] a0, a1;
    logic [15:0] w0, w1;
    int          n;
    int          busy_clks;
  } vec_t;

  int ncmp = 0;
  int nbad = 0;
  int viol = 0;
  int done_cnt, busy_cyc;
  bit hold_rdy;
  logic [15:0] mem [logic [22:0]];
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic [22:0] acc_a[$];
  logic [15:0] acc_d[$];
  int          acc_w[$];
  bit          acc_k[$];
  int          cur_w;
  logic [22:0] cur_a;
  logic [15:0] cur_d;
  bit          cur_k;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clr();
    done_cnt = 0; busy_cyc = 0; cur_w = 0; hold_rdy = 1'b0;
    tx_q.delete(); rx_q.delete();
    acc_a.delete(); acc_d.delete(); acc_w.delete(); acc_k.delete();
  endtask

  // One rising edge: observe outputs, then play memory, byte source and byte sink.
  task automatic tick();
    @(posedge clk);
    start = 1'b0;
    abort = 1'b0;
    if (dma_oe && (dma_we_hi || dma_we_lo)) viol++;
    if ((dma_oe || dma_we_hi || dma_we_lo) && !dma_req) viol++;
    if (dma_we_hi != dma_we_lo) viol++;
    if (done) done_cnt++;
    if (busy) busy_cyc++;
    if (dma_we_hi || dma_oe) begin
      cur_w++; cur_a = dma_addr; cur_d = dma_data; cur_k = dma_oe;
    end else if (cur_w != 0) begin
      acc_a.push_back(cur_a); acc_d.push_back(cur_d);
      acc_w.push_back(cur_w); acc_k.push_back(cur_k);
      if (!cur_k) mem[cur_a] = cur_d;
      cur_w = 0;
    end
    mem_do = mem.exists(dma_addr) ? mem[dma_addr] : 16'h0000;
    if (tx_q.size() > 0) begin
      din = tx_q[0];
      din_valid = 1'b1;
      if (din_ready) void'(tx_q.pop_front());
    end else begin
      din_valid = 1'b0;
    end
    dout_ready = !hold_rdy;
    if (dout_valid && dout_ready) rx_q.push_back(dout);
  endtask

  task automatic wait_idle();
    int k = 0;
    tick();
    while (busy && k < 2000) begin
      tick();
      k++;
    end
    chk("idle_timeout", {63'd0, busy}, 64'd0);
    tick();
    tick();
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    clr();
    if (!v.dir) begin
      if (v.n >= 1) begin tx_q.push_back(v.w0[15:8]); tx_q.push_back(v.w0[7:0]); end
      if (v.n >= 2) begin tx_q.push_back(v.w1[15:8]); tx_q.push_back(v.w1[7:0]); end
    end else begin
      if (v.n >= 1) mem[v.a0] = v.w0;
      if (v.n >= 2) mem[v.a1] = v.w1;
    end
    dir = v.dir; addr_st = v.addr; len = v.len; start = 1'b1;
    wait_idle();
    chk($sformatf("v%0d_nacc", idx), acc_a.size(), v.n);
    for (int i = 0; i < v.n; i++) begin
      if (i < acc_a.size()) begin
        chk($sformatf("v%0d_addr%0d", idx, i), acc_a[i], (i == 0) ? v.a0 : v.a1);
        chk($sformatf("v%0d_kind%0d", idx, i), acc_k[i], v.dir);
        chk($sformatf("v%0d_width%0d", idx, i), acc_w[i], 3);
        if (!v.dir) chk($sformatf("v%0d_wdata%0d", idx, i), acc_d[i], (i == 0) ? v.w0 : v.w1);
      end
    end
    if (v.dir) begin
      chk($sformatf("v%0d_nbytes", idx), rx_q.size(), 2 * v.n);
      for (int i = 0; i < 2 * v.n; i++) begin
        if (i < rx_q.size())
          chk($sformatf("v%0d_byte%0d", idx, i), rx_q[i],
              (i == 0) ? v.w0[15:8] : (i == 1) ? v.w0[7:0] : (i == 2) ? v.w1[15:8] : v.w1[7:0]);
      end
    end
    chk($sformatf("v%0d_done", idx), done_cnt, 1);
    chk($sformatf("v%0d_busy", idx), busy_cyc, v.busy_clks);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    int   k;
    int   bad;
    int   cnt;
    tbl[0] = '{1'b0, 23'h000100, 16'd2, 23'h000100, 23'h000102, 16'h1234, 16'h5678, 2, 16};
    tbl[1] = '{1'b1, 23'h000200, 16'd2, 23'h000200, 23'h000202, 16'hBEEF, 16'hCAFE, 2, 14};
    tbl[2] = '{1'b0, 23'h7FFFFF, 16'd2, 23'h7FFFFE, 23'h000000, 16'hA1B2, 16'hC3D4, 2, 16};
    tbl[3] = '{1'b0, 23'h000500, 16'd0, 23'h000000, 23'h000000, 16'h0000, 16'h0000, 0, 2};
    tbl[4] = '{1'b1, 23'h000600, 16'd0, 23'h000000, 23'h000000, 16'h0000, 16'h0000, 0, 2};
    tbl[5] = '{1'b1, 23'h000301, 16'd1, 23'h000300, 23'h000000, 16'h5AA5, 16'h0000, 1, 8};
    tbl[6] = '{1'b0, 23'h123457, 16'd1, 23'h123456, 23'h000000, 16'h9ABC, 16'h0000, 1, 9};

    rst = 1'b1; start = 1'b0; dir = 1'b0; abort = 1'b0; din = 8'h00; din_valid = 1'b0;
    dout_ready = 1'b1; addr_st = '0; len = '0; mem_do = '0;
    clr();
    repeat (3) tick();
    chk("reset_outputs", {din_ready, dout, dout_valid, dma_addr, dma_data, dma_oe,
                          dma_we_lo, dma_we_hi, dma_req, busy, done}, 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

    // Sink stalls 5 clks on the first byte: byte and bus ownership must hold.
    clr();
    mem[23'h000200] = 16'hBEEF;
    hold_rdy = 1'b1;
    dir = 1'b1; addr_st = 23'h000200; len = 16'd1; start = 1'b1;
    k = 0;
    do begin tick(); k++; end while (!dout_valid && k < 50);
    chk("stall_reach_send", {63'd0, dout_valid}, 64'd1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!(dout_valid && dout == 8'hBE && dma_req)) bad++;
    end
    chk("stall_hold", bad, 0);
    hold_rdy = 1'b0;
    wait_idle();
    chk("stall_nbytes", rx_q.size(), 2);
    if (rx_q.size() == 2) chk("stall_bytes", {rx_q[0], rx_q[1]}, 16'hBEEF);
    chk("stall_done", done_cnt, 1);

    // Abort in the second clk of the write pulse.
    clr();
    tx_q.push_back(8'h12); tx_q.push_back(8'h34); tx_q.push_back(8'h56); tx_q.push_back(8'h78);
    dir = 1'b0; addr_st = 23'h000100; len = 16'd2; start = 1'b1;
    k = 0;
    do begin tick(); k++; end while (!dma_we_hi && k < 50);
    tick();
    abort = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!busy) break;
      if (!dma_we_hi) cnt++;
    end
    tx_q.delete();
    tick(); tick();
    chk("abort_pulse_nacc", acc_a.size(), 1);
    if (acc_w.size() > 0) chk("abort_pulse_width", acc_w[0], 3);
    chk("abort_hold_fin_clks", cnt, 2);
    chk("abort_no_done", done_cnt, 0);
    run_vec(tbl[0], 10);

    // Abort while waiting for the second byte of a word.
    clr();
    tx_q.push_back(8'h11);
    dir = 1'b0; addr_st = 23'h000400; len = 16'd1; start = 1'b1;
    repeat (4) tick();
    abort = 1'b1;
    wait_idle();
    chk("abort_collect_nacc", acc_a.size(), 0);
    chk("abort_collect_done", done_cnt, 0);

    // Start together with abort in IDLE launches nothing.
    clr();
    dir = 1'b0; addr_st = 23'h000700; len = 16'd1; start = 1'b1; abort = 1'b1;
    repeat (5) tick();
    chk("start_abort_busy", busy_cyc, 0);

    // A second start while busy is ignored.
    clr();
    mem[23'h000200] = 16'hBEEF;
    dir = 1'b1; addr_st = 23'h000200; len = 16'd1; start = 1'b1;
    repeat (3) tick();
    dir = 1'b0; addr_st = 23'h000800; len = 16'd3; start = 1'b1;
    wait_idle();
    repeat (3) tick();
    chk("busy_start_busy", busy_cyc, 8);
    chk("busy_start_nacc", acc_a.size(), 1);
    chk("busy_start_done", done_cnt, 1);

    // Reset during the read pulse drops the bus at once.
    clr();
    dir = 1'b1; addr_st = 23'h000200; len = 16'd1; start = 1'b1;
    k = 0;
    do begin tick(); k++; end while (!dma_oe && k < 50);
    chk("rst_reach_pulse", {63'd0, dma_oe}, 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_drop", {dma_oe, dma_req, busy, dout_valid}, 64'd0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_no_done", done_cnt, 0);

    chk("strobe_rules", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
